// File: rtl/eth_rx_seq_pkg.sv
// Shared types and defaults for the RX frame sequencer: FSM state encoding,
// default frame limits and the statistics counter width.
package eth_rx_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DESC    = 2'd1,
    PAYLOAD = 2'd2,
    FLUSH   = 2'd3
  } seq_state_t;

  localparam int ETH_MAX_FRAME_LEN = 1522;
  localparam int ETH_LEN_WIDTH     = 11;
  localparam int STAT_WIDTH        = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] cnt,
                                                    input logic                  ev);
    if (ev && !(&cnt)) return cnt + STAT_WIDTH'(1);
    return cnt;
  endfunction

endpackage

// File: rtl/eth_rx_frame_sequencer_if.sv
// Stream bundle around the RX frame sequencer: length FIFO input, RX byte input,
// descriptor output and forwarded byte output. master = sequencer side.
interface eth_rx_frame_sequencer_if #(
  parameter int LENGTH_WIDTH = 11
);
  logic [LENGTH_WIDTH-1:0] s_len_tdata;
  logic                    s_len_tvalid;
  logic                    s_len_tready;

  logic [7:0]              s_axis_tdata;
  logic                    s_axis_tvalid;
  logic                    s_axis_tready;
  logic                    s_axis_tlast;
  logic                    s_axis_tuser;

  logic [LENGTH_WIDTH-1:0] m_desc_len;
  logic                    m_desc_valid;
  logic                    m_desc_ready;

  logic [7:0]              m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic                    m_axis_tlast;
  logic                    m_axis_tuser;

  modport master (
    input  s_len_tdata, s_len_tvalid,
    output s_len_tready,
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    output s_axis_tready,
    output m_desc_len, m_desc_valid,
    input  m_desc_ready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready
  );

  modport slave (
    output s_len_tdata, s_len_tvalid,
    input  s_len_tready,
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
    input  s_axis_tready,
    input  m_desc_len, m_desc_valid,
    output m_desc_ready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready
  );

endinterface

// File: rtl/eth_rx_seq_stats.sv
// Saturating frame statistics counters (ok / err / dropped) with a synchronous
// clear that wins over any increment in the same cycle.
module eth_rx_seq_stats
  import eth_rx_seq_pkg::*;
(
  input  logic                  logic_clk,
  input  logic                  logic_rst_n,
  input  logic                  stat_clear,
  input  logic                  ev_ok,
  input  logic                  ev_err,
  input  logic                  ev_drop,
  output logic [STAT_WIDTH-1:0] frames_ok,
  output logic [STAT_WIDTH-1:0] frames_err,
  output logic [STAT_WIDTH-1:0] frames_dropped
);

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      frames_ok      <= '0;
      frames_err     <= '0;
      frames_dropped <= '0;
    end else if (stat_clear) begin
      frames_ok      <= '0;
      frames_err     <= '0;
      frames_dropped <= '0;
    end else begin
      frames_ok      <= sat_inc(frames_ok, ev_ok);
      frames_err     <= sat_inc(frames_err, ev_err);
      frames_dropped <= sat_inc(frames_dropped, ev_drop);
    end
  end

endmodule

// File: rtl/eth_rx_frame_sequencer.sv
// Pops one length entry per RX frame, issues a length descriptor, then gates that
// frame's bytes through. Optional statistics under `ETH_RX_SEQ_STATS_EN.
//
// state   | meaning
// IDLE    | waiting for a length entry (popped while enable is high)
// DESC    | descriptor held valid until the consumer accepts it
// PAYLOAD | zero-latency byte pass-through, remaining counts down to the last byte
// FLUSH   | discarding bytes up to the next tlast (oversize or overlong frame)
module eth_rx_frame_sequencer
  import eth_rx_seq_pkg::*;
#(
  parameter int LENGTH_WIDTH  = ETH_LEN_WIDTH,
  parameter int MAX_FRAME_LEN = ETH_MAX_FRAME_LEN
) (
  input  logic                       logic_clk,
  input  logic                       logic_rst_n,
  input  logic                       enable,
  eth_rx_frame_sequencer_if.master   bus,
  output logic                       err_mismatch,
  output logic                       err_oversize,
  output logic                       busy
`ifdef ETH_RX_SEQ_STATS_EN
  ,
  input  logic                       stat_clear,
  output logic [STAT_WIDTH-1:0]      stat_frames_ok,
  output logic [STAT_WIDTH-1:0]      stat_frames_err,
  output logic [STAT_WIDTH-1:0]      stat_frames_dropped
`endif
);

  seq_state_t              state_q, state_d;
  logic [LENGTH_WIDTH-1:0] remaining_q, remaining_d;
  logic [LENGTH_WIDTH-1:0] desc_len_q;
  logic                    desc_valid_q;

  logic [LENGTH_WIDTH:0]   len_plus1;
  logic                    oversize;
  logic                    len_pop;
  logic                    beat;
  logic                    last_cnt;

  logic                    s_len_tready;
  logic                    s_axis_tready;
  logic [7:0]              m_axis_tdata;
  logic                    m_axis_tvalid;
  logic                    m_axis_tlast;
  logic                    m_axis_tuser;

  // One extra bit so an all-ones entry reads as 2^LENGTH_WIDTH bytes.
  assign len_plus1 = {1'b0, bus.s_len_tdata} + (LENGTH_WIDTH+1)'(1);
  assign oversize  = len_plus1 > (LENGTH_WIDTH+1)'(MAX_FRAME_LEN);
  assign len_pop   = (state_q == IDLE) && enable && bus.s_len_tvalid;
  assign beat      = bus.s_axis_tvalid && bus.m_axis_tready;
  assign last_cnt  = (remaining_q == '0);

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    s_len_tready  = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    err_mismatch  = 1'b0;
    err_oversize  = 1'b0;
    case (state_q)
      IDLE: begin
        s_len_tready = enable;
        if (len_pop) begin
          remaining_d = bus.s_len_tdata;
          if (oversize) begin
            state_d      = FLUSH;
            err_oversize = 1'b1;
          end else begin
            state_d = DESC;
          end
        end
      end
      DESC: begin
        if (bus.m_desc_ready) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        m_axis_tvalid = bus.s_axis_tvalid;
        s_axis_tready = bus.m_axis_tready;
        m_axis_tdata  = bus.s_axis_tdata;
        // Either source of "last" ends the forwarded frame; disagreement marks it bad.
        if (last_cnt || bus.s_axis_tlast) begin
          m_axis_tlast = 1'b1;
          m_axis_tuser = (last_cnt && bus.s_axis_tlast) ? bus.s_axis_tuser : 1'b1;
        end
        if (beat) begin
          err_mismatch = last_cnt != bus.s_axis_tlast;
          if (last_cnt) begin
            state_d = bus.s_axis_tlast ? IDLE : FLUSH;
          end else if (bus.s_axis_tlast) begin
            state_d = IDLE;
          end else begin
            remaining_d = remaining_q - LENGTH_WIDTH'(1);
          end
        end
      end
      FLUSH: begin
        s_axis_tready = 1'b1;
        if (bus.s_axis_tvalid && bus.s_axis_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      desc_len_q   <= '0;
      desc_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      desc_valid_q <= (state_d == DESC);
      if (len_pop) desc_len_q <= len_plus1[LENGTH_WIDTH-1:0];
    end
  end

  assign busy              = (state_q != IDLE);
  assign bus.s_len_tready  = s_len_tready;
  assign bus.s_axis_tready = s_axis_tready;
  assign bus.m_desc_len    = desc_len_q;
  assign bus.m_desc_valid  = desc_valid_q;
  assign bus.m_axis_tdata  = m_axis_tdata;
  assign bus.m_axis_tvalid = m_axis_tvalid;
  assign bus.m_axis_tlast  = m_axis_tlast;
  assign bus.m_axis_tuser  = m_axis_tuser;

`ifdef ETH_RX_SEQ_STATS_EN
  logic ev_ok, ev_err;

  assign ev_ok  = (state_q == PAYLOAD) && beat && m_axis_tlast && !m_axis_tuser;
  assign ev_err = (state_q == PAYLOAD) && beat && m_axis_tlast && m_axis_tuser;

  eth_rx_seq_stats u_stats (
    .logic_clk      (logic_clk),
    .logic_rst_n    (logic_rst_n),
    .stat_clear     (stat_clear),
    .ev_ok          (ev_ok),
    .ev_err         (ev_err),
    .ev_drop        (err_oversize),
    .frames_ok      (stat_frames_ok),
    .frames_err     (stat_frames_err),
    .frames_dropped (stat_frames_dropped)
  );
`endif

endmodule

// File: tb/tb_eth_rx_frame_sequencer.sv
// Randomized bench for eth_rx_frame_sequencer against a frame-level reference model,
// followed by directed enable-drop and mid-frame reset checks.
module tb_eth_rx_frame_sequencer;
  import eth_rx_seq_pkg::*;

  localparam int LW   = 11;
  localparam int MAXL = 1522;

  logic logic_clk = 1'b0;
  logic logic_rst_n = 1'b0;
  logic enable = 1'b0;
  logic err_mismatch, err_oversize, busy;
`ifdef ETH_RX_SEQ_STATS_EN
  logic stat_clear = 1'b0;
  logic [31:0] stat_frames_ok, stat_frames_err, stat_frames_dropped;
`endif

  always #5 logic_clk = ~logic_clk;

  eth_rx_frame_sequencer_if #(.LENGTH_WIDTH(LW)) bus ();

  eth_rx_frame_sequencer #(.LENGTH_WIDTH(LW), .MAX_FRAME_LEN(MAXL)) dut (
    .logic_clk           (logic_clk),
    .logic_rst_n         (logic_rst_n),
    .enable              (enable),
    .bus                 (bus),
    .err_mismatch        (err_mismatch),
    .err_oversize        (err_oversize),
    .busy                (busy)
`ifdef ETH_RX_SEQ_STATS_EN
    ,
    .stat_clear          (stat_clear),
    .stat_frames_ok      (stat_frames_ok),
    .stat_frames_err     (stat_frames_err),
    .stat_frames_dropped (stat_frames_dropped)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    bit         last;
    bit         user;
    bit         mism;
  } beat_t;

  int         len_list[$];
  logic [7:0] sb_data[$];
  bit         sb_last[$];
  bit         sb_user[$];
  int         exp_desc[$];
  beat_t      exp_beat[$];
  int exp_mism = 0, exp_over = 0, exp_ok = 0, exp_err = 0, exp_drop = 0;

  // Reference model: what the consumer must see for one input frame.
  task automatic add_frame(input int entry, input int actual, input bit tuser);
    logic [7:0] bytes[$];
    int fwd;
    beat_t b;
    len_list.push_back(entry);
    for (int i = 0; i < actual; i++) begin
      bytes.push_back(8'($urandom));
      sb_data.push_back(bytes[i]);
      sb_last.push_back(i == actual - 1);
      sb_user.push_back((i == actual - 1) ? tuser : 1'b0);
    end
    if (entry + 1 > MAXL) begin
      exp_over++;
      exp_drop++;
    end else begin
      exp_desc.push_back(entry + 1);
      fwd = (actual < entry + 1) ? actual : entry + 1;
      for (int i = 0; i < fwd; i++) begin
        b.data = bytes[i];
        b.last = (i == fwd - 1);
        b.mism = (i == fwd - 1) && (actual != entry + 1);
        b.user = (i == fwd - 1) && ((actual != entry + 1) || tuser);
        exp_beat.push_back(b);
      end
      if (actual != entry + 1) begin
        exp_mism++;
        exp_err++;
      end else if (tuser) exp_err++;
      else exp_ok++;
    end
  endtask

  initial begin
    int li, di, n_desc, desc_wait, seen_mism, seen_over, popped, nfwd, sent;
    bit done, len_fire, dat_fire, out_fire, desc_fire, desc_pend, tog;
    logic [LW-1:0] prev_desc_len;
    beat_t e;

    bus.s_len_tdata = '0;  bus.s_len_tvalid = 1'b0;
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0; bus.s_axis_tuser = 1'b0;
    bus.m_desc_ready = 1'b0; bus.m_axis_tready = 1'b0;

    repeat (3) @(posedge logic_clk);
    @(negedge logic_clk);
    chk("rst_busy", busy, 0);
    chk("rst_desc_valid", bus.m_desc_valid, 0);
    chk("rst_desc_len", bus.m_desc_len, 0);
    chk("rst_m_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_s_len_tready", bus.s_len_tready, 0);
    chk("rst_s_tready", bus.s_axis_tready, 0);
    chk("rst_err_mism", err_mismatch, 0);
    chk("rst_err_over", err_oversize, 0);
`ifdef ETH_RX_SEQ_STATS_EN
    chk("rst_stat_ok", stat_frames_ok, 0);
    chk("rst_stat_err", stat_frames_err, 0);
    chk("rst_stat_drop", stat_frames_dropped, 0);
`endif
    @(posedge logic_clk); #1;
    logic_rst_n = 1'b1;
    enable = 1'b1;

    add_frame(63, 64, 1'b0);
    add_frame(63, 60, 1'b0);
    add_frame(59, 64, 1'b0);
    add_frame(1599, 1600, 1'b0);
    add_frame(63, 64, 1'b0);
    add_frame(1521, 1522, 1'b0);
    add_frame(2047, 5, 1'b0);
    add_frame(0, 1, 1'b1);
    for (int f = 0; f < 30; f++) begin
      int r, en;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        en = $urandom_range(0, 80);
        add_frame(en, en + 1, $urandom_range(0, 3) == 0);
      end else if (r == 6) begin
        en = $urandom_range(2, 80);
        add_frame(en, $urandom_range(1, en), 1'b0);
      end else if (r == 7) begin
        en = $urandom_range(0, 60);
        add_frame(en, en + $urandom_range(2, 10), $urandom_range(0, 1));
      end else if (r == 8) begin
        add_frame($urandom_range(MAXL, 2047), $urandom_range(1, 30), 1'b0);
      end else begin
        add_frame(0, 1, $urandom_range(0, 1));
      end
    end

    li = 0; di = 0; n_desc = 0; desc_wait = 10; seen_mism = 0; seen_over = 0;
    done = 1'b0; desc_pend = 1'b0; tog = 1'b0; prev_desc_len = '0;
    for (int cyc = 0; cyc < 60000 && !done; cyc++) begin
      @(negedge logic_clk);
      len_fire  = bus.s_len_tvalid && bus.s_len_tready;
      dat_fire  = bus.s_axis_tvalid && bus.s_axis_tready;
      out_fire  = bus.m_axis_tvalid && bus.m_axis_tready;
      desc_fire = bus.m_desc_valid && bus.m_desc_ready;

      if (busy) chk("len_ready_busy", bus.s_len_tready, 0);
      if (bus.m_axis_tvalid) begin
        chk("s_ready_mirror", bus.s_axis_tready, bus.m_axis_tready);
        chk("m_valid_src", bus.s_axis_tvalid, 1);
      end
      if (desc_pend) begin
        chk("desc_hold_valid", bus.m_desc_valid, 1);
        chk("desc_hold_len", bus.m_desc_len, prev_desc_len);
      end
      if (len_fire) begin
        chk("oversize_pulse", err_oversize, (len_list[li] + 1 > MAXL));
        li++;
      end else chk("oversize_idle", err_oversize, 0);
      if (desc_fire) begin
        n_desc++;
        if (exp_desc.size() == 0) chk("desc_extra", 0, 1);
        else chk("desc_len", bus.m_desc_len, exp_desc.pop_front());
      end
      if (out_fire) begin
        if (exp_beat.size() == 0) chk("beat_extra", bus.m_axis_tdata, 9'h100);
        else begin
          e = exp_beat.pop_front();
          chk("beat_data", bus.m_axis_tdata, e.data);
          chk("beat_last", bus.m_axis_tlast, e.last);
          chk("beat_user", bus.m_axis_tuser, e.user);
          chk("mismatch_pulse", err_mismatch, e.mism);
        end
      end else chk("mismatch_idle", err_mismatch, 0);
      if (err_mismatch) seen_mism++;
      if (err_oversize) seen_over++;
      if (dat_fire) di++;
      desc_pend     = bus.m_desc_valid && !bus.m_desc_ready;
      prev_desc_len = bus.m_desc_len;
      done = (li == len_list.size()) && (di == sb_data.size()) &&
             (exp_beat.size() == 0) && (exp_desc.size() == 0) && !busy;

      if (!done) begin
        @(posedge logic_clk); #1;
        if (len_fire || !bus.s_len_tvalid) begin
          bus.s_len_tvalid = (li < len_list.size()) && ($urandom_range(0, 3) != 0);
          bus.s_len_tdata  = (li < len_list.size()) ? LW'(len_list[li]) : '0;
        end
        if (dat_fire || !bus.s_axis_tvalid) begin
          bus.s_axis_tvalid = (di < sb_data.size()) && ($urandom_range(0, 3) != 0);
          bus.s_axis_tdata  = (di < sb_data.size()) ? sb_data[di] : 8'h00;
          bus.s_axis_tlast  = (di < sb_data.size()) ? sb_last[di] : 1'b0;
          bus.s_axis_tuser  = (di < sb_data.size()) ? sb_user[di] : 1'b0;
        end
        tog = ~tog;
        bus.m_axis_tready = (cyc < 1500) ? tog : ($urandom_range(0, 3) != 0);
        if (bus.m_desc_valid) begin
          if (desc_wait > 0) begin
            bus.m_desc_ready = 1'b0;
            desc_wait--;
          end else bus.m_desc_ready = 1'b1;
        end else begin
          bus.m_desc_ready = 1'b0;
          desc_wait = (n_desc == 0) ? 10 : $urandom_range(0, 12);
        end
      end
    end
    chk("traffic_done", done, 1);
    chk("beats_left", exp_beat.size(), 0);
    chk("desc_left", exp_desc.size(), 0);
    chk("mismatch_count", seen_mism, exp_mism);
    chk("oversize_count", seen_over, exp_over);
    chk("idle_after_traffic", busy, 0);
`ifdef ETH_RX_SEQ_STATS_EN
    chk("stat_ok", stat_frames_ok, exp_ok);
    chk("stat_err", stat_frames_err, exp_err);
    chk("stat_drop", stat_frames_dropped, exp_drop);
    @(posedge logic_clk); #1;
    stat_clear = 1'b1;
    @(posedge logic_clk); #1;
    stat_clear = 1'b0;
    @(negedge logic_clk);
    chk("stat_clr_ok", stat_frames_ok, 0);
    chk("stat_clr_err", stat_frames_err, 0);
    chk("stat_clr_drop", stat_frames_dropped, 0);
`endif

    // Enable dropped mid-frame: frame must finish, no further pops while low.
    @(posedge logic_clk); #1;
    bus.s_len_tdata = LW'(39); bus.s_len_tvalid = 1'b1;
    bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0; bus.s_axis_tuser = 1'b0;
    bus.m_axis_tready = 1'b1; bus.m_desc_ready = 1'b1;
    popped = 0; nfwd = 0; sent = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge logic_clk);
      if (!enable) chk("len_ready_en_low", bus.s_len_tready, 0);
      if (bus.s_len_tvalid && bus.s_len_tready) popped++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        chk("p6_data", bus.m_axis_tdata, nfwd);
        chk("p6_last", bus.m_axis_tlast, nfwd == 39);
        nfwd++;
      end
      if (bus.s_axis_tvalid && bus.s_axis_tready) sent++;
      if (sent == 40 && !busy && c > 60) break;
      @(posedge logic_clk); #1;
      if (nfwd >= 10) begin
        enable = 1'b0;
        bus.s_len_tvalid = 1'b1;
        bus.s_len_tdata  = LW'(20);
      end else if (popped >= 1) bus.s_len_tvalid = 1'b0;
      bus.s_axis_tvalid = (sent < 40);
      bus.s_axis_tdata  = 8'(sent);
      bus.s_axis_tlast  = (sent == 39);
    end
    chk("p6_fwd", nfwd, 40);
    chk("p6_pops", popped, 1);
    chk("p6_idle", busy, 0);
`ifdef ETH_RX_SEQ_STATS_EN
    chk("p6_stat_ok", stat_frames_ok, 1);
`endif

    // Re-enable, start the next frame, then reset in the middle of it.
    @(posedge logic_clk); #1;
    enable = 1'b1;
    nfwd = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge logic_clk);
      if (bus.s_len_tvalid && bus.s_len_tready) popped++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) nfwd++;
      if (nfwd >= 5) break;
      @(posedge logic_clk); #1;
      if (popped >= 2) bus.s_len_tvalid = 1'b0;
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = 8'($urandom);
      bus.s_axis_tlast  = 1'b0;
    end
    chk("p6b_fwd", nfwd, 5);
    chk("p6b_busy", busy, 1);
    @(posedge logic_clk); #1;
    logic_rst_n = 1'b0;
    enable = 1'b0;
    bus.s_len_tvalid = 1'b0;
    @(negedge logic_clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_desc_valid", bus.m_desc_valid, 0);
    chk("mrst_desc_len", bus.m_desc_len, 0);
    chk("mrst_m_tvalid", bus.m_axis_tvalid, 0);
    chk("mrst_m_tdata", bus.m_axis_tdata, 0);
    chk("mrst_m_tlast", bus.m_axis_tlast, 0);
    chk("mrst_m_tuser", bus.m_axis_tuser, 0);
    chk("mrst_s_tready", bus.s_axis_tready, 0);
    chk("mrst_s_len_tready", bus.s_len_tready, 0);
    chk("mrst_err_mism", err_mismatch, 0);
    chk("mrst_err_over", err_oversize, 0);
`ifdef ETH_RX_SEQ_STATS_EN
    chk("mrst_stat_ok", stat_frames_ok, 0);
    chk("mrst_stat_err", stat_frames_err, 0);
    chk("mrst_stat_drop", stat_frames_dropped, 0);
`endif
    @(posedge logic_clk); #1;
    logic_rst_n = 1'b1;
    bus.s_axis_tvalid = 1'b0;
    @(negedge logic_clk);
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
